// File: rtl/ser_tx_ne.sv
// Falling-edge serial transmitter: MSB-first shift-out with valid/ready intake.
// Define SER_TX_PARITY_EN to append an even-parity bit after the data bits.
module ser_tx_ne #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SER_TX_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sframe_q, sframe_d;
  logic             done_q, done_d;
`ifdef SER_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // The MSB of the shift register is the line; zeros shift in behind the data.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sframe_d = sframe_q;
    done_d   = 1'b0;
`ifdef SER_TX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          state_d  = SHIFT;
          sh_d     = din;
          cnt_d    = CW'(WIDTH - 1);
          sframe_d = 1'b1;
`ifdef SER_TX_PARITY_EN
          par_d    = ^din;
`endif
        end
      end
      SHIFT: begin
        sh_d = {sh_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
`ifdef SER_TX_PARITY_EN
          state_d = PARITY;
          sh_d    = {par_q, {(WIDTH-1){1'b0}}};
`else
          state_d  = DONE;
          sframe_d = 1'b0;
          done_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef SER_TX_PARITY_EN
      PARITY: begin
        state_d  = DONE;
        sh_d     = '0;
        sframe_d = 1'b0;
        done_d   = 1'b1;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        sh_d     = '0;
        cnt_d    = '0;
        sframe_d = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      sframe_q <= sframe_d;
      done_q   <= done_d;
`ifdef SER_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign sout      = sh_q[WIDTH-1];
  assign sframe    = sframe_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign din_ready = (state_q == IDLE);

endmodule

// File: tb/tb_ser_tx_ne.sv
// Bench for ser_tx_ne: expected line samples are built per frame
// from the word, then compared cycle by cycle at the rising edge.
module tb_ser_tx_ne;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sframe;
  logic       busy;
  logic       done;

  int npass = 0;
  int ntot  = 0;

  // sample = {sout, sframe, done, busy, din_ready}
  logic [4:0] exp_q[$];

  ser_tx_ne #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sout      (sout),
    .sframe    (sframe),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_idle();
    exp_q.push_back(5'b00001);
  endtask

  task automatic model_frame(input logic [7:0] w);
    for (int b = 7; b >= 0; b--)
      exp_q.push_back({w[b], 1'b1, 1'b0, 1'b1, 1'b0});
`ifdef SER_TX_PARITY_EN
    exp_q.push_back({^w, 1'b1, 1'b0, 1'b1, 1'b0});
`endif
    exp_q.push_back(5'b00110);
    model_idle();
  endtask

  task automatic step();
    logic [4:0] e;
    @(negedge clk);
    @(posedge clk);
    chk("ready_vs_busy", din_ready, !busy);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("line", {sout, sframe, done, busy, din_ready}, e);
    end
  endtask

  // Offer w for one accept edge, then scramble din to prove capture.
  task automatic send(input logic [7:0] w);
    din       = w;
    din_valid = 1'b1;
    model_frame(w);
    step();
    din_valid = 1'b0;
    din       = 8'($urandom);
`ifdef SER_TX_PARITY_EN
    repeat (10) step();
`else
    repeat (9) step();
`endif
  endtask

  initial begin
    rst       = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    #1;
    chk("rst_state", {sout, sframe, done, busy, din_ready}, 5'b00001);
    @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    step();

    send(8'hA5);
    send(8'h07);
    send(8'h00);
    send(8'hFF);

    for (int k = 0; k < 8; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        model_idle();
        step();
      end
      send(8'($urandom));
    end

    // valid held through two frames, din changed right after accept
    din       = 8'h3C;
    din_valid = 1'b1;
    model_frame(8'h3C);
    model_frame(8'hC3);
    step();
    din = 8'hC3;
`ifdef SER_TX_PARITY_EN
    repeat (10) step();
`else
    repeat (9) step();
`endif
    step();
    din_valid = 1'b0;
`ifdef SER_TX_PARITY_EN
    repeat (10) step();
`else
    repeat (9) step();
`endif

    // abort mid-frame while bit 3 is on the line
    din       = 8'h5A;
    din_valid = 1'b1;
    for (int b = 7; b >= 3; b--)
      exp_q.push_back({din[b], 1'b1, 1'b0, 1'b1, 1'b0});
    step();
    din_valid = 1'b0;
    repeat (4) step();
    chk("q_drained", exp_q.size(), 0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_clear", {sout, sframe, done, busy, din_ready}, 5'b00001);
    din       = 8'h81;
    din_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    chk("rst_no_capture", {sout, sframe, done, busy, din_ready}, 5'b00001);
    rst       = 1'b1;
    din_valid = 1'b0;
    model_idle();
    step();
    send(8'hFF);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
